// File: rtl/sram_ctrl_pkg.sv
// rtl/sram_ctrl_pkg.sv - shared types and constants for the SRAM RW port controller
package sram_ctrl_pkg;

    typedef enum logic [0:0] {
        ST_INIT,
        ST_RUN
    } state_e;

    localparam int unsigned DEF_DATA_W = 256;
    localparam int unsigned DEF_MASK_W = 32;
    localparam int unsigned LANE_W     = DEF_DATA_W / DEF_MASK_W;

    localparam logic [31:0] STAT_MAX = 32'hFFFF_FFFF;

    function automatic int unsigned lane_width(input int unsigned data_w, input int unsigned mask_w);
        return data_w / mask_w;
    endfunction

endpackage

// File: rtl/sram_resp_fifo.sv
// rtl/sram_resp_fifo.sv - in-order read response FIFO, head entry drives the output
module sram_resp_fifo #(
    parameter  int DATA_W = 256,
    parameter  int DEPTH  = 2,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_push_data,
    input  logic              i_pop,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic [CNT_W-1:0]  o_count
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [CNT_W-1:0]  r_count;
    logic              w_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_pop   = i_pop && o_valid;
    assign o_valid = (r_count != '0);
    assign o_data  = r_mem[r_rptr];
    assign o_count = r_count;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_wptr <= next_ptr(r_wptr);
            if (w_pop)  r_rptr <= next_ptr(r_rptr);
            case ({i_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            // The upstream credit check makes this unreachable; firing means the credit math broke.
            assert (!(i_push && r_count == CNT_W'(DEPTH)));
        end
    end

    always_ff @(posedge clock) begin
        if (i_push) r_mem[r_wptr] <= i_push_data;
    end

endmodule

// File: rtl/sram_rw_port_ctrl.sv
// rtl/sram_rw_port_ctrl.sv - valid/ready initiator for an RW0 SRAM macro with post-reset zero-fill
// Optional access/stall counters are built when SRAM_CTRL_STAT_EN is defined.
module sram_rw_port_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int ADDR_W     = 9,
    parameter int DATA_W     = 256,
    parameter int MASK_W     = 32,
    parameter int RESP_DEPTH = 2,
    parameter int INIT_ZERO  = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [MASK_W-1:0] req_wmask,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              init_done,
    output logic [ADDR_W-1:0] sram_addr,
    output logic              sram_en,
    output logic              sram_wmode,
    output logic [MASK_W-1:0] sram_wmask,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic [31:0]       stat_reads,
    output logic [31:0]       stat_writes,
    output logic [31:0]       stat_stalls
);

    localparam int CNT_W = $clog2(RESP_DEPTH + 1);

    state_e            r_state;
    logic [ADDR_W-1:0] r_init_cnt;
    logic              r_init_done;
    logic              r_inflight;
    logic [CNT_W-1:0]  w_fifo_count;
    logic              w_fifo_valid;
    logic              w_run;
    logic              w_init;
    logic              w_rd_credit;
    logic              w_req_ready;
    logic              w_fire;
    logic              w_rd_fire;

    // Gating with reset_n keeps ready/en low while reset is held, independent of the entry state.
    assign w_run       = reset_n && (r_state == ST_RUN);
    assign w_init      = reset_n && (r_state == ST_INIT);
    assign w_rd_credit = (int'(w_fifo_count) + int'(r_inflight)) < RESP_DEPTH;
    assign w_req_ready = w_run && (req_write || w_rd_credit);
    assign w_fire      = req_valid && w_req_ready;
    assign w_rd_fire   = w_fire && !req_write;

    assign req_ready  = w_req_ready;
    assign init_done  = r_init_done;
    assign resp_valid = w_fifo_valid;

    always_comb begin
        sram_en    = w_fire;
        sram_wmode = w_fire && req_write;
        sram_addr  = req_addr;
        sram_wmask = req_wmask;
        sram_wdata = req_wdata;
        if (w_init) begin
            sram_en    = 1'b1;
            sram_wmode = 1'b1;
            sram_addr  = r_init_cnt;
            sram_wmask = '1;
            sram_wdata = '0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= (INIT_ZERO != 0) ? ST_INIT : ST_RUN;
            r_init_cnt  <= '0;
            r_init_done <= (INIT_ZERO == 0);
            r_inflight  <= 1'b0;
        end else begin
            r_inflight <= w_rd_fire;
            case (r_state)
                ST_INIT: begin
                    r_init_cnt <= r_init_cnt + 1'b1;
                    if (&r_init_cnt) begin
                        r_state     <= ST_RUN;
                        r_init_done <= 1'b1;
                    end
                end
                default: r_state <= ST_RUN;
            endcase
            assert (lane_width(DATA_W, MASK_W) * MASK_W == DATA_W);
        end
    end

    // Macro rdata is valid the cycle after a read; capture it then so backpressure never stalls the array.
    sram_resp_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (RESP_DEPTH)
    ) u_resp_fifo (
        .clock       (clock),
        .reset_n     (reset_n),
        .i_push      (r_inflight),
        .i_push_data (sram_rdata),
        .i_pop       (resp_ready),
        .o_valid     (w_fifo_valid),
        .o_data      (resp_rdata),
        .o_count     (w_fifo_count)
    );

`ifdef SRAM_CTRL_STAT_EN
    logic [31:0] r_stat_reads;
    logic [31:0] r_stat_writes;
    logic [31:0] r_stat_stalls;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_stat_reads  <= '0;
            r_stat_writes <= '0;
            r_stat_stalls <= '0;
        end else begin
            if (w_rd_fire && r_stat_reads != STAT_MAX)
                r_stat_reads <= r_stat_reads + 1'b1;
            if (w_fire && req_write && r_stat_writes != STAT_MAX)
                r_stat_writes <= r_stat_writes + 1'b1;
            if (w_run && req_valid && !w_req_ready && r_stat_stalls != STAT_MAX)
                r_stat_stalls <= r_stat_stalls + 1'b1;
        end
    end

    assign stat_reads  = r_stat_reads;
    assign stat_writes = r_stat_writes;
    assign stat_stalls = r_stat_stalls;
`else
    assign stat_reads  = '0;
    assign stat_writes = '0;
    assign stat_stalls = '0;
`endif

endmodule

// File: tb/tb_sram_rw_port_ctrl.sv
// tb/tb_sram_rw_port_ctrl.sv - directed self-checking bench for sram_rw_port_ctrl with a behavioural RW0 macro
module tb_sram_rw_port_ctrl;

    localparam int AW = 4;
    localparam int DW = 32;
    localparam int MW = 4;
    localparam int RD = 2;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_write = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic [MW-1:0] req_wmask = '0;
    logic          resp_ready = 1'b1;
    logic          req_ready;
    logic          resp_valid;
    logic [DW-1:0] resp_rdata;
    logic          init_done;
    logic [AW-1:0] sram_addr;
    logic          sram_en;
    logic          sram_wmode;
    logic [MW-1:0] sram_wmask;
    logic [DW-1:0] sram_wdata;
    logic [DW-1:0] sram_rdata;
    logic [31:0]   stat_reads;
    logic [31:0]   stat_writes;
    logic [31:0]   stat_stalls;

    logic [DW-1:0] mem [16];
    logic [AW-1:0] bp_addr [4] = '{4'd3, 4'd9, 4'd5, 4'd3};
    logic [DW-1:0] bp_exp  [4] = '{32'hA5A5_A5A5, 32'h1111_11FF, 32'h0, 32'hA5A5_A5A5};

    int n_vec = 0;
    int n_bad = 0;
    int acc;
    int got;

    sram_rw_port_ctrl #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .MASK_W     (MW),
        .RESP_DEPTH (RD),
        .INIT_ZERO  (1)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_wmask   (req_wmask),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_rdata  (resp_rdata),
        .init_done   (init_done),
        .sram_addr   (sram_addr),
        .sram_en     (sram_en),
        .sram_wmode  (sram_wmode),
        .sram_wmask  (sram_wmask),
        .sram_wdata  (sram_wdata),
        .sram_rdata  (sram_rdata),
        .stat_reads  (stat_reads),
        .stat_writes (stat_writes),
        .stat_stalls (stat_stalls)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (sram_en) begin
            if (sram_wmode) begin
                for (int l = 0; l < MW; l++)
                    if (sram_wmask[l]) mem[sram_addr][l*8 +: 8] <= sram_wdata[l*8 +: 8];
            end else begin
                sram_rdata <= mem[sram_addr];
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic init_seq(input string tag);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 4'd9;
        req_wdata = '1;
        req_wmask = '1;
        for (int i = 0; i < 16; i++) begin
            #1;
            chk(tag, {init_done, req_ready, resp_valid, sram_en, sram_wmode, sram_addr, sram_wmask, sram_wdata},
                {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'(i), 4'hF, 32'h0});
            step();
        end
        req_valid = 1'b0;
        req_write = 1'b0;
        #1;
        chk({tag, "_done"}, {init_done, sram_en, req_ready, resp_valid}, 4'b1010);
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [MW-1:0] m);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = a;
        req_wdata = d;
        req_wmask = m;
        #1;
        chk("wr_fire", {req_ready, sram_en, sram_wmode, sram_addr, sram_wmask, sram_wdata}, {3'b111, a, m, d});
        step();
        req_valid = 1'b0;
        req_write = 1'b0;
    endtask

    task automatic rd(input logic [AW-1:0] a);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = a;
        #1;
        chk("rd_fire", {req_ready, sram_en, sram_wmode, sram_addr}, {3'b110, a});
        step();
        req_valid = 1'b0;
    endtask

    task automatic expect_resp(input string tag, input logic [DW-1:0] d);
        #1;
        chk({tag, "_lat"}, 64'(resp_valid), 64'd0);
        step();
        #1;
        chk({tag, "_data"}, {resp_valid, resp_rdata}, {1'b1, d});
        step();
        #1;
        chk({tag, "_drain"}, 64'(resp_valid), 64'd0);
    endtask

    initial begin
        repeat (2) step();
        chk("reset", {req_ready, resp_valid, sram_en, sram_wmode, init_done}, 5'b00000);

        reset_n = 1'b1;
        init_seq("init1");

        rd(4'd5);
        expect_resp("rd_zero", 32'h0);

        wr(4'd3, 32'hA5A5_A5A5, 4'hF);
        rd(4'd3);
        expect_resp("rd_a5", 32'hA5A5_A5A5);

        wr(4'd9, 32'h1111_1111, 4'hF);
        wr(4'd9, 32'hFFFF_FFFF, 4'h1);
        rd(4'd9);
        expect_resp("mask", 32'h1111_11FF);

        resp_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 4; i++) begin
            req_valid = 1'b1;
            req_write = 1'b0;
            req_addr  = bp_addr[acc];
            #1;
            if (req_ready) acc++;
            step();
        end
        req_addr = bp_addr[acc];
        #1;
        chk("bp_accepted", 64'(acc), 64'd2);
        chk("bp_stall", {req_ready, resp_valid, resp_rdata}, {1'b0, 1'b1, 32'hA5A5_A5A5});
        resp_ready = 1'b1;
        got = 0;
        for (int cyc = 0; cyc < 30 && got < 4; cyc++) begin
            req_valid = (acc < 4);
            req_addr  = bp_addr[(acc < 4) ? acc : 0];
            #1;
            if (resp_valid) begin
                chk("bp_order", 64'(resp_rdata), 64'(bp_exp[got]));
                got++;
            end
            if (req_valid && req_ready) acc++;
            step();
        end
        req_valid = 1'b0;
        chk("bp_got", 64'(got), 64'd4);
        chk("bp_acc", 64'(acc), 64'd4);

        wr(4'd7, 32'h3C3C_3C3C, 4'hF);
        rd(4'd7);
        wr(4'd7, 32'h5555_5555, 4'hF);
        #1;
        chk("raw_old", {resp_valid, resp_rdata}, {1'b1, 32'h3C3C_3C3C});
        step();
        rd(4'd7);
        expect_resp("raw_new", 32'h5555_5555);

        resp_ready = 1'b0;
        rd(4'd3);
        rd(4'd9);
        #1;
        chk("pre_rst", {resp_valid, req_ready}, 2'b10);
        reset_n = 1'b0;
        #1;
        chk("rst_mid", {resp_valid, req_ready, sram_en, sram_wmode, init_done}, 5'b00000);
        step();
        step();
        chk("rst_hold", {resp_valid, req_ready, sram_en, init_done}, 4'b0000);
        resp_ready = 1'b1;
        reset_n = 1'b1;
        init_seq("init2");
        repeat (3) begin
            step();
            #1;
            chk("no_stale", 64'(resp_valid), 64'd0);
        end

`ifndef SRAM_CTRL_STAT_EN
        chk("stat_tie", {|stat_reads, |stat_writes, |stat_stalls}, 3'b000);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
